wb_rr_arbiter: RTL and testbench

//   Parametrised N-way arbiter that produces a registered grant for the wishbone interconnect.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/Priority_encoder.sv | 44 ++++
 rtl/wb_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the wishbone grant arbiter.
//   ARB_*    : arbitration policy selectors
//   BLOCK_*  : grant hold/release policy selectors
//   arb_state_e : arbiter FSM states
//   idx_width() : width of a port index, never narrower than 1 bit
package wb_arb_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

  localparam int BLOCK_NONE = 0;
  localparam int BLOCK_REQ  = 1;
  localparam int BLOCK_ACK  = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/Priority_encoder.sv
// Priority encoder over a request vector.
//   input_unencoded  in  WIDTH   request bits
//   output_valid     out 1       any bit set
//   output_encoded   out EW      index of the winning bit (0 when none)
//   output_unencoded out WIDTH   one-hot of the winning bit (0 when none)
// LSB_HIGH_PRIORITY=1 makes bit 0 the winner among set bits; 0 makes bit WIDTH-1 win.
module Priority_encoder
  import wb_arb_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 1,
  localparam int EW               = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [EW-1:0]    output_encoded,
  output logic [WIDTH-1:0] output_unencoded
);

  // Scan from the lowest-priority end so the last hit is the winner.
  always_comb begin
    output_valid     = |input_unencoded;
    output_encoded   = '0;
    output_unencoded = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int unsigned i = int'(WIDTH); i > 0; i--) begin
        if (input_unencoded[i-1]) begin
          output_encoded          = EW'(i - 1);
          output_unencoded        = '0;
          output_unencoded[i-1]   = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < int'(WIDTH); i++) begin
        if (input_unencoded[i]) begin
          output_encoded          = EW'(i);
          output_unencoded        = '0;
          output_unencoded[i]     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-way registered grant arbiter for the wishbone shared-slave mux.
//   clk_i            in  1       clock, rising edge
//   rst_ni           in  1       asynchronous reset, active low
//   req_i            in  PORTS   request per port
//   ack_i            in  PORTS   release pulse per port (BLOCK_MODE=2 only)
//   grant_o          out PORTS   one-hot registered grant
//   grant_valid_o    out 1       any grant active
//   grant_encoded_o  out IDX_W   index of the granted port, 0 when idle
// Fixed-priority or round-robin selection; a grant can be held until the
// owner drops its request or pulses its ack.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int PORTS             = 4,
  parameter int ARB_MODE          = ARB_RR,
  parameter int LSB_HIGH_PRIORITY = 1,
  parameter int BLOCK_MODE        = BLOCK_REQ,
  localparam int IDX_W            = idx_width(PORTS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PORTS-1:0] req_i,
  input  logic [PORTS-1:0] ack_i,
  output logic [PORTS-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_encoded_o
);

  arb_state_e       state_q;
  logic [PORTS-1:0] grant_q;
  logic [IDX_W-1:0] enc_q;
  logic [PORTS-1:0] rr_mask_q;

  logic             release_c;
  logic             regrant_c;
  logic [PORTS-1:0] arb_req;
  logic [PORTS-1:0] masked_req;

  logic             m_valid, u_valid;
  logic [IDX_W-1:0] m_idx, u_idx;
  logic [PORTS-1:0] m_onehot, u_onehot;

  logic [PORTS-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  logic             load_en;
  logic             clear_en;
  logic [PORTS-1:0] load_onehot;
  logic [IDX_W-1:0] load_idx;

  // Ports that follow the winner in round-robin order: strictly above it
  // when bit 0 is the default favourite, strictly below it otherwise.
  // Winning the last port in scan order yields an empty mask, which makes
  // the unmasked encoder take over and wraps the pointer inside PORTS.
  function automatic logic [PORTS-1:0] next_mask(input logic [PORTS-1:0] oh);
    if (LSB_HIGH_PRIORITY != 0) return ~(oh | (oh - PORTS'(1)));
    else                        return oh - PORTS'(1);
  endfunction

  always_comb begin
    release_c = 1'b0;
    case (BLOCK_MODE)
      BLOCK_NONE: release_c = 1'b1;
      BLOCK_REQ:  release_c = ~|(req_i & grant_q);
      BLOCK_ACK:  release_c = |(ack_i & grant_q);
      default:    release_c = 1'b1;
    endcase
  end

  // The current owner is excluded from the release arbitration; it may only
  // keep the bus when nobody else is asking.
  assign regrant_c  = |(req_i & grant_q);
  assign arb_req    = (state_q == GRANTED) ? (req_i & ~grant_q) : req_i;
  assign masked_req = (ARB_MODE == ARB_RR) ? (arb_req & rr_mask_q) : '0;

  Priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_masked_enc (
    .input_unencoded  (masked_req),
    .output_valid     (m_valid),
    .output_encoded   (m_idx),
    .output_unencoded (m_onehot)
  );

  Priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_unmasked_enc (
    .input_unencoded  (arb_req),
    .output_valid     (u_valid),
    .output_encoded   (u_idx),
    .output_unencoded (u_onehot)
  );

  assign win_valid  = u_valid;
  assign win_onehot = m_valid ? m_onehot : u_onehot;
  assign win_idx    = m_valid ? m_idx    : u_idx;

  always_comb begin
    load_en     = 1'b0;
    clear_en    = 1'b0;
    load_onehot = win_onehot;
    load_idx    = win_idx;
    unique case (state_q)
      IDLE: load_en = win_valid;
      GRANTED: begin
        if (release_c) begin
          if (win_valid) begin
            load_en = 1'b1;
          end else if (regrant_c) begin
            load_en     = 1'b1;
            load_onehot = grant_q;
            load_idx    = enc_q;
          end else begin
            clear_en = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      enc_q     <= '0;
      rr_mask_q <= '1;
    end else if (load_en) begin
      state_q   <= GRANTED;
      grant_q   <= load_onehot;
      enc_q     <= load_idx;
      rr_mask_q <= next_mask(load_onehot);
    end else if (clear_en) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      enc_q     <= '0;
    end
  end

  assign grant_o         = grant_q;
  assign grant_valid_o   = |grant_q;
  assign grant_encoded_o = enc_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N = 6;
  // per-instance configuration: ports, round robin, block mode, lsb-high
  localparam int CP[N]  = '{4, 4, 4, 4, 3, 4};
  localparam int CRR[N] = '{0, 1, 1, 1, 1, 0};
  localparam int CBK[N] = '{0, 0, 1, 2, 0, 1};
  localparam int CLS[N] = '{1, 1, 1, 1, 1, 0};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] ack   = '0;

  logic [3:0] g0, g1, g2, g3, g5;
  logic [2:0] g4;
  logic       v0, v1, v2, v3, v4, v5;
  logic [1:0] e0, e1, e2, e3, e4, e5;

  logic [3:0] dg[N];
  logic       dv[N];
  logic [1:0] de[N];

  int mg[N];
  int ml[N];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.PORTS(4), .ARB_MODE(0), .LSB_HIGH_PRIORITY(1), .BLOCK_MODE(0)) u_fix0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack),
    .grant_o(g0), .grant_valid_o(v0), .grant_encoded_o(e0));
  wb_rr_arbiter #(.PORTS(4), .ARB_MODE(1), .LSB_HIGH_PRIORITY(1), .BLOCK_MODE(0)) u_rr0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack),
    .grant_o(g1), .grant_valid_o(v1), .grant_encoded_o(e1));
  wb_rr_arbiter #(.PORTS(4), .ARB_MODE(1), .LSB_HIGH_PRIORITY(1), .BLOCK_MODE(1)) u_rr1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack),
    .grant_o(g2), .grant_valid_o(v2), .grant_encoded_o(e2));
  wb_rr_arbiter #(.PORTS(4), .ARB_MODE(1), .LSB_HIGH_PRIORITY(1), .BLOCK_MODE(2)) u_rr2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack),
    .grant_o(g3), .grant_valid_o(v3), .grant_encoded_o(e3));
  wb_rr_arbiter #(.PORTS(3), .ARB_MODE(1), .LSB_HIGH_PRIORITY(1), .BLOCK_MODE(0)) u_p3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2:0]), .ack_i(ack[2:0]),
    .grant_o(g4), .grant_valid_o(v4), .grant_encoded_o(e4));
  wb_rr_arbiter #(.PORTS(4), .ARB_MODE(0), .LSB_HIGH_PRIORITY(0), .BLOCK_MODE(1)) u_msb1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_i(ack),
    .grant_o(g5), .grant_valid_o(v5), .grant_encoded_o(e5));

  always_comb begin
    dg[0] = g0; dg[1] = g1; dg[2] = g2; dg[3] = g3; dg[4] = {1'b0, g4}; dg[5] = g5;
    dv[0] = v0; dv[1] = v1; dv[2] = v2; dv[3] = v3; dv[4] = v4;         dv[5] = v5;
    de[0] = e0; de[1] = e1; de[2] = e2; de[3] = e3; de[4] = e4;         de[5] = e5;
  end

  // ---------------- behavioural model ----------------
  // Walk the ports in priority order from the starting point and return the
  // first requester other than 'excl', or -1.
  function automatic int pick(int i, int last, int excl, logic [3:0] r);
    int p = CP[i];
    int start;
    int idx;
    if (CRR[i] != 0) start = (CLS[i] != 0) ? (last + 1) % p : (last - 1 + p) % p;
    else             start = (CLS[i] != 0) ? 0 : p - 1;
    for (int k = 0; k < p; k++) begin
      idx = (CLS[i] != 0) ? (start + k) % p : (start - k + p) % p;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int next_grant(int i, int g, int last, logic [3:0] r, logic [3:0] a);
    bit rel;
    int n;
    if (g < 0) return pick(i, last, -1, r);
    case (CBK[i])
      0:       rel = 1'b1;
      1:       rel = !r[g];
      default: rel = a[g];
    endcase
    if (!rel) return g;
    n = pick(i, last, g, r);
    if (n >= 0) return n;
    return r[g] ? g : -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mg[i] = -1;
        ml[i] = (CLS[i] != 0) ? CP[i] - 1 : 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = next_grant(i, mg[i], ml[i], req, ack);
        mg[i] = n;
        if (n >= 0) ml[i] = n;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [3:0] xg;
      logic       xv;
      logic [1:0] xe;
      xg = (mg[i] < 0) ? 4'b0000 : (4'b0001 << mg[i]);
      xv = (mg[i] >= 0);
      xe = (mg[i] < 0) ? 2'd0 : 2'(mg[i]);
      n_cmp++;
      if (dg[i] !== xg || dv[i] !== xv || de[i] !== xe) begin
        n_bad++;
        $display("FAIL model_inst%0d t=%0t: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                 i, $time, dg[i], dv[i], de[i], xg, xv, xe);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  localparam logic [7:0] TBL[20] = '{
    8'hF_0, 8'hF_0, 8'hA_2, 8'h5_1, 8'h0_4, 8'h6_0, 8'h6_4, 8'h9_8,
    8'h3_2, 8'h3_1, 8'hC_0, 8'h4_4, 8'h4_0, 8'h7_2, 8'h1_1, 8'h0_0,
    8'h8_0, 8'hB_8, 8'hE_2, 8'hD_F};

  initial begin
    // 1. reset with all requests high
    rst_n = 1'b0;
    req   = 4'b1111;
    step(); step(); step();
    chk("rst_grant", g1, 4'b0000);
    chk("rst_valid", {3'b0, v1}, 4'b0000);
    chk("rst_enc",   {2'b0, e1}, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("first_grant_lsb", g0, 4'b0001);
    chk("first_grant_msb", g5, 4'b1000);

    // 2. fixed priority, re-arbitrate every cycle
    req = 4'b1010;
    step();
    chk("fix_grant_1010", g0, 4'b0010);
    chk("fix_enc_1010",   {2'b0, e0}, 4'b0001);
    req = 4'b1000;
    step();
    chk("fix_grant_1000", g0, 4'b1000);

    // 3. round robin rotation
    do_reset();
    req = 4'b1111;
    step(); chk("rr_seq0", g1, 4'b0001);
    step(); chk("rr_seq1", g1, 4'b0010);
    step(); chk("rr_seq2", g1, 4'b0100);
    step(); chk("rr_seq3", g1, 4'b1000);
    chk("p3_wrap", {1'b0, g4}, 4'b0001);
    step(); chk("rr_seq4", g1, 4'b0001);
    req = 4'b0101;
    step(); chk("rr_alt0", g1, 4'b0100);
    step(); chk("rr_alt1", g1, 4'b0001);
    step(); chk("rr_alt2", g1, 4'b0100);

    // 4. hold until request drops
    do_reset();
    req = 4'b0100;
    step(); chk("blk1_grant", g2, 4'b0100);
    req = 4'b0101;
    step(); chk("blk1_hold0", g2, 4'b0100);
    step(); chk("blk1_hold1", g2, 4'b0100);
    req = 4'b0001;
    step(); chk("blk1_handover", g2, 4'b0001);

    // 5. hold until ack
    do_reset();
    req = 4'b0010;
    step(); chk("blk2_grant", g3, 4'b0010);
    req = 4'b0000;
    step(); chk("blk2_req_drop", g3, 4'b0010);
    ack = 4'b1000;
    step(); chk("blk2_foreign_ack", g3, 4'b0010);
    ack = 4'b0010;
    step(); chk("blk2_release", g3, 4'b0000);
    chk("blk2_release_valid", {3'b0, v3}, 4'b0000);
    ack = 4'b0000;
    req = 4'b0010;
    step(); chk("blk2_regrant", g3, 4'b0010);
    ack = 4'b0010;
    step(); chk("blk2_sole_regrant", g3, 4'b0010);
    req = 4'b0011;
    step(); chk("blk2_pass_on", g3, 4'b0001);
    ack = 4'b0000;

    // 6. reset in the middle of a grant
    do_reset();
    req = 4'b0100;
    step(); chk("mid_grant", g2, 4'b0100);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", g2, 4'b0000);
    chk("mid_rst_valid", {3'b0, v2}, 4'b0000);
    #2 rst_n = 1'b1;
    req = 4'b1111;
    step(); chk("post_rst_grant", g2, 4'b0001);

    // 7. mixed request/ack table, checked by the model only
    do_reset();
    for (int t = 0; t < 20; t++) begin
      logic [7:0] v;
      v   = TBL[t];
      req = v[7:4];
      ack = v[3:0];
      step();
    end
    req = '0;
    ack = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
